// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_pkg
// Purpose  : Shared types and width helpers for the traffic sensor
//            conditioner (debounce state encoding, counter widths).
// Revision : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    // Per-channel debounce state; the conditioned level is 1 in HIGH and FALL_WAIT.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RISE_WAIT = 2'd1,
        HIGH      = 2'd2,
        FALL_WAIT = 2'd3
    } deb_state_t;

    // Width able to hold the value 0..cycles inclusive.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sensor_debounce
// Purpose  : One sensor channel: SYNC_STAGES-deep synchronizer, four-state
//            debounce FSM with registered level and arrival pulse, and an
//            optional stuck-high detector (enabled by macro STUCK_DETECT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module sensor_debounce
    import traffic_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
`ifdef STUCK_DETECT_EN
    output logic o_stuck,
`endif
    output logic o_arrive
);

    localparam int                  c_CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0]  c_DEB_LAST = c_CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0]  c_ONE      = c_CNT_W'(1);
    localparam logic                c_SINGLE   = (DEBOUNCE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_synced;
    deb_state_t             r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_inc;
    logic                   r_level;
    logic                   r_arrive;
    logic                   w_fall;

    // Synchronizer chain; only the last stage is used downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    assign w_synced  = r_sync[SYNC_STAGES-1];
    assign w_cnt_inc = r_cnt + c_ONE;

    // A fall is confirmed this cycle (used by the stuck detector to clear at the same edge).
    assign w_fall = !w_synced &&
                    (((r_state == FALL_WAIT) && (w_cnt_inc == c_DEB_LAST)) ||
                     ((r_state == HIGH) && c_SINGLE));

    // Debounce FSM with registered level and one-cycle arrival pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_level  <= 1'b0;
            r_arrive <= 1'b0;
        end else begin
            r_arrive <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_synced) begin
                        if (c_SINGLE) begin
                            r_state  <= HIGH;
                            r_cnt    <= '0;
                            r_level  <= 1'b1;
                            r_arrive <= 1'b1;
                        end else begin
                            r_state <= RISE_WAIT;
                            r_cnt   <= c_ONE;
                        end
                    end
                end
                RISE_WAIT: begin
                    if (!w_synced) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (w_cnt_inc == c_DEB_LAST) begin
                        r_state  <= HIGH;
                        r_cnt    <= '0;
                        r_level  <= 1'b1;
                        r_arrive <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                HIGH: begin
                    if (!w_synced) begin
                        if (c_SINGLE) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                            r_level <= 1'b0;
                        end else begin
                            r_state <= FALL_WAIT;
                            r_cnt   <= c_ONE;
                        end
                    end
                end
                FALL_WAIT: begin
                    if (w_synced) begin
                        r_state <= HIGH;
                        r_cnt   <= '0;
                    end else if (w_cnt_inc == c_DEB_LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign o_arrive = r_arrive;

`ifdef STUCK_DETECT_EN
    localparam int                  c_STK_W   = cnt_width(STUCK_CYCLES);
    localparam logic [c_STK_W-1:0]  c_STK_MAX = c_STK_W'(STUCK_CYCLES);

    logic [c_STK_W-1:0] r_high_time;
    logic [c_STK_W-1:0] w_high_inc;
    logic               r_stuck;

    assign w_high_inc = r_high_time + c_STK_W'(1);

    // High-time counter; stuck flag is sticky until the debounced level confirms a fall.
    always_ff @(posedge clk) begin
        if (reset || !r_level || w_fall) begin
            r_high_time <= '0;
            r_stuck     <= 1'b0;
        end else if (!r_stuck) begin
            r_high_time <= w_high_inc;
            if (w_high_inc == c_STK_MAX) begin
                r_stuck <= 1'b1;
            end
        end
    end

    assign o_level = r_level & ~r_stuck;
    assign o_stuck = r_stuck;
`else
    assign o_level = r_level;
`endif

endmodule
`default_nettype wire

// File: rtl/traffic_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : traffic_sensor_conditioner
// Purpose  : Conditions the two raw car sensors into clean SA/SB levels,
//            arrival pulses and saturating arrival counters.
//            Optional stuck-sensor detection with macro STUCK_DETECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8,
    parameter int STUCK_CYCLES    = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             raw_a,
    input  logic             raw_b,
    input  logic             clear_counts,
    output logic             SA,
    output logic             SB,
    output logic             arrive_a,
    output logic             arrive_b,
`ifdef STUCK_DETECT_EN
    output logic             stuck_a,
    output logic             stuck_b,
`endif
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic             w_arrive_a;
    logic             w_arrive_b;
    logic [CNT_W-1:0] r_count_a;
    logic [CNT_W-1:0] r_count_b;

    sensor_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_deb_a (
        .clk      (clk),
        .reset    (reset),
        .i_raw    (raw_a),
        .o_level  (SA),
`ifdef STUCK_DETECT_EN
        .o_stuck  (stuck_a),
`endif
        .o_arrive (w_arrive_a)
    );

    sensor_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_deb_b (
        .clk      (clk),
        .reset    (reset),
        .i_raw    (raw_b),
        .o_level  (SB),
`ifdef STUCK_DETECT_EN
        .o_stuck  (stuck_b),
`endif
        .o_arrive (w_arrive_b)
    );

    // Saturating arrival counters; a clear coincident with an arrival leaves a count of 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count_a <= '0;
            r_count_b <= '0;
        end else begin
            if (clear_counts) begin
                r_count_a <= w_arrive_a ? c_CNT_ONE : '0;
                r_count_b <= w_arrive_b ? c_CNT_ONE : '0;
            end else begin
                if (w_arrive_a && (r_count_a != c_CNT_MAX)) begin
                    r_count_a <= r_count_a + c_CNT_ONE;
                end
                if (w_arrive_b && (r_count_b != c_CNT_MAX)) begin
                    r_count_b <= r_count_b + c_CNT_ONE;
                end
            end
        end
    end

    assign arrive_a = w_arrive_a;
    assign arrive_b = w_arrive_b;
    assign count_a  = r_count_a;
    assign count_b  = r_count_b;

endmodule
`default_nettype wire

// File: tb/tb_traffic_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_sensor_conditioner
// Purpose  : Self-checking bench: directed scenarios plus randomized sensor
//            traffic compared against a behavioural run-length model.
//            Stuck-detect scenario compiled in with macro STUCK_DETECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_sensor_conditioner;

    localparam int S    = 2;
    localparam int D    = 4;
    localparam int CW   = 2;
    localparam int STK  = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          raw_a;
    logic          raw_b;
    logic          clear_counts;
    logic          SA;
    logic          SB;
    logic          arrive_a;
    logic          arrive_b;
    logic [CW-1:0] count_a;
    logic [CW-1:0] count_b;
`ifdef STUCK_DETECT_EN
    logic          stuck_a;
    logic          stuck_b;
`endif

    int errors = 0;
    int checks = 0;

    traffic_sensor_conditioner #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CW),
        .STUCK_CYCLES    (STK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .raw_a        (raw_a),
        .raw_b        (raw_b),
        .clear_counts (clear_counts),
        .SA           (SA),
        .SB           (SB),
        .arrive_a     (arrive_a),
        .arrive_b     (arrive_b),
`ifdef STUCK_DETECT_EN
        .stuck_a      (stuck_a),
        .stuck_b      (stuck_b),
`endif
        .count_a      (count_a),
        .count_b      (count_b)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: the level flips after D consecutive synchronized
    // samples that disagree with it; samples reach the decision S edges
    // after the raw input is captured.
    // ------------------------------------------------------------------
    logic [S-1:0] m_sh     [2];
    int           m_run    [2];
    bit           m_level  [2];
    bit           m_arrive [2];
    int           m_cnt    [2];
    int           m_ht     [2];
    bit           m_stuck  [2];

    always @(posedge clk) begin
        logic rw [2];
        logic s;
        bit   was;
        bit   fell;
        rw[0] = raw_a;
        rw[1] = raw_b;
        for (int c = 0; c < 2; c++) begin
            if (reset) begin
                m_sh[c]     = '0;
                m_run[c]    = 0;
                m_level[c]  = 0;
                m_arrive[c] = 0;
                m_cnt[c]    = 0;
                m_ht[c]     = 0;
                m_stuck[c]  = 0;
            end else begin
                if (clear_counts)
                    m_cnt[c] = m_arrive[c] ? 1 : 0;
                else if (m_arrive[c] && m_cnt[c] < CMAX)
                    m_cnt[c] = m_cnt[c] + 1;
                s       = m_sh[c][S-1];
                m_sh[c] = {m_sh[c][S-2:0], rw[c]};
                was         = m_level[c];
                fell        = 0;
                m_arrive[c] = 0;
                if (s != m_level[c]) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == D) begin
                        m_level[c]  = s;
                        m_run[c]    = 0;
                        m_arrive[c] = s;
                        fell        = !s;
                    end
                end else begin
                    m_run[c] = 0;
                end
                if (!was || fell) begin
                    m_ht[c]    = 0;
                    m_stuck[c] = 0;
                end else if (!m_stuck[c]) begin
                    m_ht[c] = m_ht[c] + 1;
                    if (m_ht[c] == STK) m_stuck[c] = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; raw_a = 1'b0; raw_b = 1'b0; clear_counts = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; raw_a = 1'b1; raw_b = 1'b1; clear_counts = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({SA, SB, arrive_a, arrive_b, count_a, count_b} !== '0) begin
                errors++;
                $display("FAIL reset_hold: got SA=%b SB=%b arr=%b%b ca=%0d cb=%0d, want all 0",
                         SA, SB, arrive_a, arrive_b, count_a, count_b);
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (SA !== (k == 6) || SB !== (k == 6) || arrive_a !== (k == 6)) begin
                errors++;
                $display("FAIL reset_release_latency edge %0d: got SA=%b SB=%b arrive_a=%b, want %b",
                         k, SA, SB, arrive_a, (k == 6));
            end
        end
    endtask

    task automatic test_clean_arrival();
        do_reset();
        raw_a = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (SA !== (k == 6) || arrive_a !== (k == 6) || SB !== 1'b0) begin
                errors++;
                $display("FAIL clean_arrival edge %0d: got SA=%b arrive_a=%b SB=%b, want SA=%b arrive=%b SB=0",
                         k, SA, arrive_a, SB, (k == 6), (k == 6));
            end
        end
        tick();
        checks++;
        if (arrive_a !== 1'b0 || SA !== 1'b1 || count_a !== 2'd1 || count_b !== 2'd0) begin
            errors++;
            $display("FAIL clean_arrival_count: got arrive_a=%b SA=%b ca=%0d cb=%0d, want 0 1 1 0",
                     arrive_a, SA, count_a, count_b);
        end
    endtask

    task automatic test_glitch();
        raw_b = 1'b1;
        repeat (3) tick();
        raw_b = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (SB !== 1'b0 || arrive_b !== 1'b0) begin
                errors++;
                $display("FAIL glitch_b: got SB=%b arrive_b=%b, want 0 0", SB, arrive_b);
            end
        end
        raw_a = 1'b0;
        repeat (2) tick();
        raw_a = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (SA !== 1'b1 || arrive_a !== 1'b0) begin
                errors++;
                $display("FAIL glitch_a: got SA=%b arrive_a=%b, want 1 0", SA, arrive_a);
            end
        end
        checks++;
        if (count_a !== 2'd1 || count_b !== 2'd0) begin
            errors++;
            $display("FAIL glitch_counts: got ca=%0d cb=%0d, want 1 0", count_a, count_b);
        end
    endtask

    task automatic test_saturation_clear();
        bit seen;
        do_reset();
        for (int p = 0; p < 5; p++) begin
            raw_a = 1'b1;
            repeat (8) tick();
            raw_a = 1'b0;
            repeat (8) tick();
        end
        checks++;
        if (count_a !== 2'd3 || count_b !== 2'd0) begin
            errors++;
            $display("FAIL saturation: got ca=%0d cb=%0d, want 3 0", count_a, count_b);
        end
        raw_a = 1'b1;
        seen  = 0;
        for (int k = 0; k < 12 && !seen; k++) begin
            tick();
            if (arrive_a === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL clear_arrive_wait: arrive_a never seen within 12 cycles, want a pulse");
        end
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        checks++;
        if (count_a !== 2'd1) begin
            errors++;
            $display("FAIL clear_with_arrive: got ca=%0d, want 1", count_a);
        end
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        checks++;
        if (count_a !== 2'd0 || count_b !== 2'd0) begin
            errors++;
            $display("FAIL clear_alone: got ca=%0d cb=%0d, want 0 0", count_a, count_b);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        raw_a = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (SA !== 1'b0 || arrive_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold: got SA=%b arrive_a=%b, want 0 0", SA, arrive_a);
        end
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (SA !== (k == 6)) begin
                errors++;
                $display("FAIL reset_mid_requalify edge %0d: got SA=%b, want %b", k, SA, (k == 6));
            end
        end
    endtask

`ifdef STUCK_DETECT_EN
    task automatic test_stuck();
        bit seen;
        do_reset();
        raw_b = 1'b1;
        seen  = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            if (SB === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL stuck_rise_wait: SB never rose within 10 cycles, want 1");
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (stuck_b !== (k == 8) || SB !== (k < 8)) begin
                errors++;
                $display("FAIL stuck_set cycle %0d: got stuck_b=%b SB=%b, want %b %b",
                         k, stuck_b, SB, (k == 8), (k < 8));
            end
        end
        raw_b = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (stuck_b !== (k < 6) || SB !== 1'b0) begin
                errors++;
                $display("FAIL stuck_clear edge %0d: got stuck_b=%b SB=%b, want %b 0",
                         k, stuck_b, SB, (k < 6));
            end
        end
    endtask
`endif

    task automatic test_random();
        int  hold_a;
        int  hold_b;
        bit  exp_sa;
        bit  exp_sb;
        do_reset();
        hold_a = 0;
        hold_b = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (hold_a == 0) begin raw_a = $urandom_range(0, 1); hold_a = $urandom_range(1, 9); end
            if (hold_b == 0) begin raw_b = $urandom_range(0, 1); hold_b = $urandom_range(1, 9); end
            hold_a--;
            hold_b--;
            clear_counts = ($urandom_range(0, 19) == 0);
            reset        = ($urandom_range(0, 299) == 0);
            tick();
            exp_sa = m_level[0];
            exp_sb = m_level[1];
`ifdef STUCK_DETECT_EN
            exp_sa = m_level[0] & ~m_stuck[0];
            exp_sb = m_level[1] & ~m_stuck[1];
            checks++;
            if (stuck_a !== m_stuck[0] || stuck_b !== m_stuck[1]) begin
                errors++;
                $display("FAIL random_stuck cyc %0d: got %b%b, want %b%b",
                         cyc, stuck_a, stuck_b, m_stuck[0], m_stuck[1]);
            end
`endif
            checks++;
            if (SA !== exp_sa || arrive_a !== m_arrive[0] || count_a !== CW'(m_cnt[0])) begin
                errors++;
                $display("FAIL random_a cyc %0d: got SA=%b arr=%b cnt=%0d, want %b %b %0d",
                         cyc, SA, arrive_a, count_a, exp_sa, m_arrive[0], m_cnt[0]);
            end
            checks++;
            if (SB !== exp_sb || arrive_b !== m_arrive[1] || count_b !== CW'(m_cnt[1])) begin
                errors++;
                $display("FAIL random_b cyc %0d: got SB=%b arr=%b cnt=%0d, want %b %b %0d",
                         cyc, SB, arrive_b, count_b, exp_sb, m_arrive[1], m_cnt[1]);
            end
        end
        reset        = 1'b0;
        clear_counts = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        raw_a        = 1'b0;
        raw_b        = 1'b0;
        clear_counts = 1'b0;
        @(negedge clk);
        test_reset();
        test_clean_arrival();
        test_glitch();
        test_saturation_clear();
        test_reset_mid();
`ifdef STUCK_DETECT_EN
        test_stuck();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_sensor_conditioner.md
Name: traffic_sensor_conditioner

Overview:
Upstream front end for the traffic light controller. It takes the two raw, asynchronous, bouncy car sensors (street A, street B) and produces the clean, synchronous SA/SB levels that the controller consumes. Each channel also provides a one-cycle arrival pulse and a saturating vehicle count for the monitoring logic.

Parameters:
SYNC_STAGES, 2, synchronizer flop depth per channel (allowed range 2..4)
DEBOUNCE_CYCLES, 4, consecutive identical synced samples required to change a debounced level (allowed range 1..255)
CNT_W, 8, width of each vehicle counter
STUCK_CYCLES, 64, stuck-high threshold in cycles; used only when STUCK_DETECT_EN is defined

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
raw_a  input  1  raw street-A sensor, asynchronous
raw_b  input  1  raw street-B sensor, asynchronous
clear_counts  input  1  synchronous clear of both counters
SA  output  1  conditioned street-A traffic present
SB  output  1  conditioned street-B traffic present
arrive_a  output  1  one-cycle pulse on each confirmed SA rise
arrive_b  output  1  one-cycle pulse on each confirmed SB rise
count_a  output  CNT_W  saturating street-A arrival count
count_b  output  CNT_W  saturating street-B arrival count
stuck_a, stuck_b  output  1 each  stuck-sensor flags; present only when STUCK_DETECT_EN is defined

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high.
- Values while reset is sampled high: sync flops 0, both FSMs IDLE, debounce counters 0, SA=SB=0, arrive_*=0, count_*=0, stuck_*=0.
- Synchronizer: a SYNC_STAGES-deep flop chain per channel. Nothing downstream uses a raw input directly.
- Debounce FSM, per channel, states IDLE, RISE_WAIT, HIGH, FALL_WAIT. The output level is 1 in HIGH and FALL_WAIT.
- IDLE: synced=1 → RISE_WAIT, counter=1; this transition confirms immediately if DEBOUNCE_CYCLES=1.
- RISE_WAIT: synced=0 → IDLE. Otherwise counter+1; when the count reaches DEBOUNCE_CYCLES → HIGH, with the arrive pulse asserted in the same cycle as the level rise.
- HIGH: synced=0 → FALL_WAIT, counter=1.
- FALL_WAIT: synced=1 → HIGH. When the low count reaches DEBOUNCE_CYCLES → IDLE.
- Latency: if raw is high at edges n..n+k, SA rises after edge n+SYNC_STAGES+DEBOUNCE_CYCLES-1. Fall latency is the same. Default latency is 5 edges.
- Glitches shorter than DEBOUNCE_CYCLES synced samples never change SA/SB or the counts.
- SA/SB and arrive_* are registered outputs with no combinational path from the inputs.
- Counters: +1 on arrive, saturating at 2^CNT_W-1 with no wrap.
- clear_counts alone: both counts become 0 on the next edge.
- clear_counts coincident with an arrive: that channel's count becomes 1.
- reset coincident with anything: reset wins.
- Channels are fully independent. Simultaneous arrivals on A and B are both counted.
- Reset mid-RISE_WAIT or mid-FALL_WAIT: the partial count is discarded, and the channel must requalify from IDLE.

Optional Feature:
Macro STUCK_DETECT_EN.
- Defined:
  - A per-channel high-time counter runs while the debounced level is 1.
  - Once it reaches STUCK_CYCLES, stuck_x is set and SA/SB for that channel is forced to 0, so the controller can cycle.
  - stuck_x is sticky until the debounced level returns to 0 (confirmed fall) or reset.
  - Arrival counting is unaffected.
- Undefined: no stuck ports and no high-time counters; SA/SB follow the debounced level exactly.

Decomposition:
- Shared package traffic_pkg holds:
  - the debounce state enum {IDLE, RISE_WAIT, HIGH, FALL_WAIT};
  - localparam width helpers, with the debounce counter width = $clog2(DEBOUNCE_CYCLES+1).
- One sub-module, sensor_debounce: synchronizer, FSM, arrive pulse and optional stuck logic for a single channel.
- Top level: two sensor_debounce instances, plus the two saturating counters and clear logic.

Test Plan:
All scenarios use the defaults unless stated otherwise.
- Reset: hold reset 3 edges with raw_a=raw_b=1 → SA=SB=0, counts 0, no arrive pulse. Release → SA rises exactly 5 edges after the first post-reset edge.
- Clean arrival: raw_a high from edge 10 → SA=1 after edge 15, arrive_a high only for that one cycle, count_a=1, SB/count_b unchanged.
- Glitch rejection: raw_b high for 3 edges, then low; also raw_a drops low for 2 edges while SA=1 → SB stays 0, SA stays 1, and no counts change.
- Saturation and clear: with CNT_W=2, drive 5 clean raw_a pulses → count_a=3. Assert clear_counts in the same cycle as arrive_a → count_a=1. Assert clear_counts alone → 0.
- Reset mid-qualification: reset pulsed during RISE_WAIT (raw_a held high) → SA=1 only 5 edges after reset deasserts.
- STUCK_DETECT_EN defined, STUCK_CYCLES=8: hold raw_b high → stuck_b=1 and SB=0 eight cycles after SB rose. Drop raw_b → stuck_b clears at the confirmed fall.
